// File: rtl/check_queue.sv
// Check stage between decode and scheduler: a DEPTH-entry FIFO with valid/ready on both
// sides that flags the all-ones-immediate unimp encoding and rewrites or passes it on.
module check_queue #(
    parameter int DEPTH      = 4,
    parameter int UNIMP_TRAP = 0,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FLUSH,
    input  logic          STALL,
    input  logic          MEM_WAIT,
    input  logic          DECODE_VALID,
    output logic          DECODE_READY,
    input  logic [31:0]   DECODE_PC,
    input  logic [6:0]    DECODE_OPCODE,
    input  logic [4:0]    DECODE_RD,
    input  logic [4:0]    DECODE_RS1,
    input  logic [4:0]    DECODE_RS2,
    input  logic [2:0]    DECODE_FUNCT3,
    input  logic [6:0]    DECODE_FUNCT7,
    input  logic [31:0]   DECODE_IMM,
    output logic          CHECK_VALID,
    input  logic          CHECK_READY,
    output logic [31:0]   CHECK_PC,
    output logic [6:0]    CHECK_OPCODE,
    output logic [4:0]    CHECK_RD,
    output logic [4:0]    CHECK_RS1,
    output logic [4:0]    CHECK_RS2,
    output logic [2:0]    CHECK_FUNCT3,
    output logic [6:0]    CHECK_FUNCT7,
    output logic [31:0]   CHECK_IMM,
    output logic [11:0]   CHECK_CSR,
    output logic          CHECK_UNIMP,
    output logic [CW-1:0] COUNT
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } entry_t;

    entry_t          mem_p0 [DEPTH];
    logic [AW-1:0]   wr_ptr_p0;
    logic [AW-1:0]   rd_ptr_p0;
    logic [CW-1:0]   count_p0;

    logic            full;
    logic            empty;
    logic            enq;
    logic            deq;
    entry_t          in_entry;
    entry_t          head;
    entry_t          head_out;
    logic            head_unimp;

    function automatic logic is_unimp(input entry_t e);
        return e.imm == 32'hffff_ffff;
    endfunction

    // Non-trapping mode turns unimp into JAL x0,0 while keeping the PC for diagnostics.
    function automatic entry_t handle_unimp(input entry_t e);
        entry_t r;
        r = e;
        if (is_unimp(e) && (UNIMP_TRAP == 0)) begin
            r        = '0;
            r.pc     = e.pc;
            r.opcode = 7'b1101111;
        end
        return r;
    endfunction

    assign full  = (count_p0 == CW'(DEPTH));
    assign empty = (count_p0 == '0);
    assign enq   = DECODE_VALID & ~full;
    assign deq   = ~empty & CHECK_READY & ~STALL & ~MEM_WAIT;

    always_comb begin
        in_entry        = '0;
        in_entry.pc     = DECODE_PC;
        in_entry.opcode = DECODE_OPCODE;
        in_entry.rd     = DECODE_RD;
        in_entry.rs1    = DECODE_RS1;
        in_entry.rs2    = DECODE_RS2;
        in_entry.funct3 = DECODE_FUNCT3;
        in_entry.funct7 = DECODE_FUNCT7;
        in_entry.imm    = DECODE_IMM;
    end

    // ---- stage p0: storage and control registers ----
    always_ff @(posedge CLK) begin
        if (enq) begin
            mem_p0[wr_ptr_p0] <= in_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_p0 <= wr_ptr_p0 + AW'(1);
            end
            if (deq) begin
                rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
            end
            if (enq && !deq) begin
                count_p0 <= count_p0 + CW'(1);
            end else if (deq && !enq) begin
                count_p0 <= count_p0 - CW'(1);
            end
        end
    end

    // ---- output: head entry presented combinationally from stored state ----
    assign head = mem_p0[rd_ptr_p0];

    always_comb begin
        head_out   = '0;
        head_unimp = 1'b0;
        if (!empty) begin
            head_out   = handle_unimp(head);
            head_unimp = is_unimp(head);
        end
    end

    assign DECODE_READY = ~full;
    assign CHECK_VALID  = ~empty;
    assign CHECK_PC     = head_out.pc;
    assign CHECK_OPCODE = head_out.opcode;
    assign CHECK_RD     = head_out.rd;
    assign CHECK_RS1    = head_out.rs1;
    assign CHECK_RS2    = head_out.rs2;
    assign CHECK_FUNCT3 = head_out.funct3;
    assign CHECK_FUNCT7 = head_out.funct7;
    assign CHECK_IMM    = head_out.imm;
    assign CHECK_CSR    = head_out.imm[11:0];
    assign CHECK_UNIMP  = head_unimp;
    assign COUNT        = count_p0;

endmodule
